// File: rtl/ccff_readback_if.sv
// ----------------------------------------------------------------------------
// ccff_readback_if
// Serial readback stream between the readback engine and its sink.
//
// Signals:
//   sout        - current serial bit (driven by the engine)
//   sout_valid  - sout holds a valid bit (driven by the engine)
//   sout_ready  - sink can take the bit (driven by the sink)
//
// Handshake: a bit transfers on a rising edge where sout_valid and
// sout_ready are both high. Once sout_valid is raised, sout and
// sout_valid hold until that transfer happens; a valid bit is never
// retracted. sout_ready may be raised or lowered freely and has no
// effect while sout_valid is low.
//
// Modports:
//   master - the engine side (drives sout/sout_valid)
//   slave  - the sink side (drives sout_ready)
// ----------------------------------------------------------------------------
interface ccff_readback_if;
    logic sout;
    logic sout_valid;
    logic sout_ready;

    modport master (
        output sout,
        output sout_valid,
        input  sout_ready
    );

    modport slave (
        input  sout,
        input  sout_valid,
        output sout_ready
    );
endinterface

// File: rtl/ccff_readback.sv
// ----------------------------------------------------------------------------
// ccff_readback
// Serial readback engine for a configuration-chain segment. On start it
// captures WIDTH configuration flip-flops in one cycle, then streams them
// out head first (bit 0 first), one bit per accepted transfer.
//
// Optional feature macro: CCFF_READBACK_PARITY_EN
//   When defined, one extra bit (the XOR reduction of the captured bits)
//   follows bit WIDTH-1, for WIDTH+1 transfers in total.
//
// Ports:
//   prog_clk   - programming clock, all state on its rising edge
//   pReset     - asynchronous active-high reset
//   cfg_bits   - parallel configuration contents, sampled only on start
//   start      - single-cycle capture request, honoured only in IDLE
//   busy       - high while the stream is in progress
//   done       - one-cycle pulse after the last bit is accepted
//   state_dbg  - current FSM state, for observation only
//   rb         - serial stream (sout / sout_valid / sout_ready)
// ----------------------------------------------------------------------------
module ccff_readback #(
    parameter int WIDTH = 32
) (
    input  logic               prog_clk,
    input  logic               pReset,
    input  logic [WIDTH-1:0]   cfg_bits,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg,
    ccff_readback_if.master    rb
);

`ifdef CCFF_READBACK_PARITY_EN
    localparam int SREG_W = WIDTH + 1;
`else
    localparam int SREG_W = WIDTH;
`endif
    // Counter must hold the full transfer count, including the parity bit.
    localparam int CNT_W = $clog2(SREG_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SREG_W-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [SREG_W-1:0]  load_val;

`ifdef CCFF_READBACK_PARITY_EN
    // Parity sits above the data so it leaves after bit WIDTH-1.
    assign load_val = {^cfg_bits, cfg_bits};
`else
    assign load_val = cfg_bits;
`endif

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d  = load_val;
                    cnt_d   = CNT_W'(SREG_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rb.sout_ready) begin
                    // Zero fill means sreg is all-zero again once drained.
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags are decoded from the next state so the outputs come
        // straight from flops with no path from start or sout_ready.
        busy_d  = (state_d == ST_SHIFT);
        valid_d = (state_d == ST_SHIFT);
        done_d  = (state_d == ST_DONE);
    end

    assign rb.sout       = sreg_q[0];
    assign rb.sout_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_ccff_readback.sv
module tb_ccff_readback;

    localparam int WIDTH = 8;
`ifdef CCFF_READBACK_PARITY_EN
    localparam int TOTAL = WIDTH + 1;
`else
    localparam int TOTAL = WIDTH;
`endif

    logic             prog_clk;
    logic             pReset;
    logic [WIDTH-1:0] cfg_bits;
    logic             start;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    ccff_readback_if rb_if ();

    ccff_readback #(.WIDTH(WIDTH)) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .cfg_bits  (cfg_bits),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg),
        .rb        (rb_if)
    );

    // ---------------- clock / reset ----------------
    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [0:0] exp_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Reference stream: head-first data bits, then even parity if enabled.
    task automatic build_expected(input logic [WIDTH-1:0] val);
        logic [0:0] par;
        exp_q.delete();
        par = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            exp_q.push_back(val[i]);
            par = par ^ val[i];
        end
`ifdef CCFF_READBACK_PARITY_EN
        exp_q.push_back(par);
`endif
    endtask

    // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1 repeating,
    //       2 = random ready. poke_start re-asserts start mid-stream with
    //       all-ones data. abort_after >= 0 fires pReset after that many accepts.
    task automatic run_stream(input logic [WIDTH-1:0] val, input int mode,
                              input bit poke_start, input int abort_after);
        int   cyc;
        int   accepts;
        int   k;
        logic r;
        logic last_sout;
        logic stalled;

        build_expected(val);
        cfg_bits        = val;
        start           = 1'b1;
        rb_if.sout_ready = 1'b0;
        step();
        start    = 1'b0;
        cfg_bits = ~val;   // capture must already be done
        cyc      = 1;
        accepts  = 0;
        stalled  = 1'b0;
        last_sout = 1'b0;
        check("busy_first", busy, 1);
        check("valid_first", rb_if.sout_valid, 1);

        while (exp_q.size() > 0 && cyc < 200) begin
            check("sout_bit", rb_if.sout, exp_q[0]);
            check("valid_hold", rb_if.sout_valid, 1);
            check("busy_hold", busy, 1);
            check("no_early_done", done, 0);
            if (stalled) check("stall_stable", rb_if.sout, last_sout);

            if (abort_after >= 0 && accepts == abort_after) begin
                pReset = 1'b1;
                #1;
                check("async_valid", rb_if.sout_valid, 0);
                check("async_busy", busy, 0);
                check("async_sout", rb_if.sout, 0);
                rb_if.sout_ready = 1'b1;
                step();
                check("abort_no_done", done, 0);
                check("abort_valid", rb_if.sout_valid, 0);
                pReset = 1'b0;
                return;
            end

            k = cyc - 1;
            case (mode)
                0:       r = 1'b1;
                1:       r = ((k % 4) == 0) || ((k % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (poke_start && cyc == 3) begin
                start    = 1'b1;
                cfg_bits = '1;
            end
            rb_if.sout_ready = r;
            last_sout = rb_if.sout;
            stalled   = ~r;
            if (r) begin
                void'(exp_q.pop_front());
                accepts++;
            end
            step();
            start = 1'b0;
            cyc++;
        end

        check("stream_drained", exp_q.size(), 0);
        check("accept_count", accepts, TOTAL);
        check("done_pulse", done, 1);
        check("done_busy_low", busy, 0);
        check("done_valid_low", rb_if.sout_valid, 0);
        if (mode == 0) check("done_latency", cyc, TOTAL + 1);

        // start during DONE is ignored; ready is irrelevant outside SHIFT.
        start            = 1'b1;
        cfg_bits         = val;
        rb_if.sout_ready = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_valid", rb_if.sout_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        pReset           = 1'b1;
        start            = 1'b0;
        cfg_bits         = '0;
        rb_if.sout_ready = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", rb_if.sout_valid, 0);
        check("rst_sout", rb_if.sout, 0);
        step();
        step();
        pReset = 1'b0;

        // Basic stream, then back-to-back starts follow naturally.
        run_stream(8'hA5, 0, 1'b0, -1);
        run_stream(8'h3C, 1, 1'b0, -1);
        run_stream(8'hA5, 0, 1'b1, -1);

        // Mid-stream async reset, then a fresh full stream.
        run_stream(8'hA5, 0, 1'b0, 4);
        run_stream(8'hA5, 0, 1'b0, -1);

        // Parity-sensitive patterns (odd and even weight).
        run_stream(8'h07, 0, 1'b0, -1);
        run_stream(8'h03, 0, 1'b0, -1);
        run_stream(8'h00, 1, 1'b0, -1);
        run_stream(8'hFF, 0, 1'b0, -1);

        // Random data with random backpressure.
        for (int n = 0; n < 20; n++) begin
            run_stream(WIDTH'($urandom), 2, 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
